// File: rtl/inst_prefetcher_if.sv
// rtl/inst_prefetcher_if.sv - memory fetch port between the instruction prefetcher and instruction memory
interface inst_prefetcher_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_req_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req_ready;
  logic              fetch_data_valid;
  logic [ADDR_W-1:0] fetch_data;

  modport master (
    output fetch_req_valid,
    output fetch_addr,
    input  fetch_req_ready,
    input  fetch_data_valid,
    input  fetch_data
  );

  modport slave (
    input  fetch_req_valid,
    input  fetch_addr,
    output fetch_req_ready,
    output fetch_data_valid,
    output fetch_data
  );
endinterface

// File: rtl/inst_prefetcher.sv
// rtl/inst_prefetcher.sv - instruction prefetch queue, decoder inst/imm16 supply and architectural PC
// pc always names the queue head word; fetch_addr runs 2*count bytes ahead of it.
module inst_prefetcher #(
  parameter int  REG_BITS    = 8,
  parameter int  NSHIFT      = 2,
  parameter int  QUEUE_WORDS = 2,
  localparam int W           = 2 * REG_BITS,
  localparam int NDIG        = W / NSHIFT,
  localparam int DW          = $clog2(NDIG),
  localparam int QW          = $clog2(QUEUE_WORDS),
  localparam int SW          = $clog2(W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_valid,
  output logic [W-1:0]      inst,
  input  logic              inst_done,
  input  logic              load_imm16,
  output logic              imm16_loaded,
  output logic [W-1:0]      imm_full,
  output logic [NSHIFT-1:0] imm_data_out,
  input  logic              next_imm_data,
  input  logic              block_prefetch,
  input  logic              write_pc,
  input  logic              ext_pc_next,
  input  logic [DW-1:0]     comp_counter,
  output logic              prefetch_idle,
  input  logic [NSHIFT-1:0] pc_data_in,
  output logic [NSHIFT-1:0] pc_data_out,
  inst_prefetcher_if.master fetch
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [QW:0]       QDEPTH   = (QW + 1)'(QUEUE_WORDS);
  localparam logic [DW-1:0]     DIG_LAST = DW'(NDIG - 1);
  localparam logic [NSHIFT-1:0] DIG_MASK = '1;

  state_t        state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [W-1:0]  inst_q, inst_d;
  logic [W-1:0]  imm_reg_q, imm_reg_d;
  logic          inst_valid_q, inst_valid_d;
  logic          imm16_loaded_q, imm16_loaded_d;
  logic [DW-1:0] imm_ptr_q, imm_ptr_d;
  logic [QW-1:0] head_q, head_d;
  logic [QW:0]   count_q, count_d;
  logic [W-1:0]  q_mem_q [QUEUE_WORDS];
  logic [W-1:0]  q_mem_d [QUEUE_WORDS];

  logic          push;
  logic          have_head;
  logic          load_pop;
  logic          inst_pop;
  logic          pop;
  logic [QW-1:0] tail;
  logic [W-1:0]  head_word;
  logic [SW-1:0] pc_sh;
  logic [SW-1:0] imm_sh;

  // Fetch FSM: a single outstanding request, guarded by free queue space
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!block_prefetch && (count_q < QDEPTH)) state_d = S_REQ;
      S_REQ:  if (fetch.fetch_req_ready) state_d = S_WAIT;
      S_WAIT: if (fetch.fetch_data_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign push      = (state_q == S_WAIT) && fetch.fetch_data_valid;
  assign have_head = (count_q != '0);
  assign tail      = head_q + count_q[QW-1:0];
  assign head_word = q_mem_q[head_q];

  // imm16 takes the head word ahead of the inst slot; a flush cancels both
  assign load_pop = load_imm16 && inst_valid_q && !imm16_loaded_q && have_head && !ext_pc_next;
  assign inst_pop = (!inst_valid_q || inst_done) && have_head && !load_pop && !ext_pc_next;
  assign pop      = load_pop || inst_pop;

  assign pc_sh  = SW'(comp_counter) * SW'(NSHIFT);
  assign imm_sh = SW'(imm_ptr_q) * SW'(NSHIFT);

  always_comb begin
    q_mem_d = q_mem_q;
    if (push) q_mem_d[tail] = fetch.fetch_data;
  end

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (ext_pc_next) begin
      count_d = '0;
      head_d  = '0;
    end else begin
      if (pop) head_d = head_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // A digit write and a pop may land together; the pop advances first
  always_comb begin
    pc_d = pc_q;
    if (pop) pc_d = pc_q + W'(2);
    if (write_pc) pc_d = (pc_d & ~(W'(DIG_MASK) << pc_sh)) | (W'(pc_data_in) << pc_sh);
  end

  // fetch_addr follows pushes only; written PC digits take effect at ext_pc_next
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (ext_pc_next) fetch_addr_d = pc_d;
    else if (push) fetch_addr_d = fetch_addr_q + W'(2);
  end

  always_comb begin
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    if (inst_pop) inst_d = head_word;
    if (ext_pc_next) inst_valid_d = 1'b0;
    else if (inst_pop) inst_valid_d = 1'b1;
    else if (inst_done) inst_valid_d = 1'b0;
  end

  always_comb begin
    imm_reg_d      = imm_reg_q;
    imm16_loaded_d = imm16_loaded_q;
    imm_ptr_d      = imm_ptr_q;
    if (load_pop) imm_reg_d = head_word;
    if (ext_pc_next || inst_done) imm16_loaded_d = 1'b0;
    else if (load_pop) imm16_loaded_d = 1'b1;
    if (ext_pc_next || inst_done || load_pop) imm_ptr_d = '0;
    else if (next_imm_data) imm_ptr_d = (imm_ptr_q == DIG_LAST) ? '0 : imm_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      fetch_addr_q   <= '0;
      inst_q         <= '0;
      imm_reg_q      <= '0;
      inst_valid_q   <= 1'b0;
      imm16_loaded_q <= 1'b0;
      imm_ptr_q      <= '0;
      head_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_addr_q   <= fetch_addr_d;
      inst_q         <= inst_d;
      imm_reg_q      <= imm_reg_d;
      inst_valid_q   <= inst_valid_d;
      imm16_loaded_q <= imm16_loaded_d;
      imm_ptr_q      <= imm_ptr_d;
      head_q         <= head_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    q_mem_q <= q_mem_d;
  end

  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign imm16_loaded = imm16_loaded_q;
  assign imm_full     = imm16_loaded_q ? imm_reg_q
                                       : {{(W - REG_BITS){inst_q[REG_BITS-1]}}, inst_q[REG_BITS-1:0]};
  assign imm_data_out = NSHIFT'(imm_full >> imm_sh);
  assign pc_data_out  = NSHIFT'(pc_q >> pc_sh);
  assign prefetch_idle = (state_q == S_IDLE);

  assign fetch.fetch_req_valid = (state_q == S_REQ);
  assign fetch.fetch_addr      = fetch_addr_q;

  // Redirecting the PC with a fetch in flight would lose the response's address
  a_flush_idle: assert property (@(posedge clk) disable iff (reset) !(ext_pc_next && state_q != S_IDLE));

endmodule

// File: tb/tb_inst_prefetcher.sv
// tb/tb_inst_prefetcher.sv - randomized self-checking bench for inst_prefetcher against a word-stream model
module tb_inst_prefetcher;

  logic        clk;
  logic        reset;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_done;
  logic        load_imm16;
  logic        imm16_loaded;
  logic [15:0] imm_full;
  logic [1:0]  imm_data_out;
  logic        next_imm_data;
  logic        block_prefetch;
  logic        write_pc;
  logic        ext_pc_next;
  logic [2:0]  comp_counter;
  logic        prefetch_idle;
  logic [1:0]  pc_data_in;
  logic [1:0]  pc_data_out;

  inst_prefetcher_if bus ();

  inst_prefetcher dut (
    .clk            (clk),
    .reset          (reset),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_done      (inst_done),
    .load_imm16     (load_imm16),
    .imm16_loaded   (imm16_loaded),
    .imm_full       (imm_full),
    .imm_data_out   (imm_data_out),
    .next_imm_data  (next_imm_data),
    .block_prefetch (block_prefetch),
    .write_pc       (write_pc),
    .ext_pc_next    (ext_pc_next),
    .comp_counter   (comp_counter),
    .prefetch_idle  (prefetch_idle),
    .pc_data_in     (pc_data_in),
    .pc_data_out    (pc_data_out),
    .fetch          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int          n_tests;
  int          n_fail;
  logic [15:0] salt;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] req_log [$];
  logic [15:0] cons_addr;
  logic [15:0] exp_fetch;
  bit          rnd_mode;
  int          fixed_delay;
  bit          resp_pending;
  int          resp_delay;
  logic [15:0] resp_addr;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  // Memory: accepts one request at a time, answers after a fixed or random delay
  initial begin
    bus.fetch_req_ready  = 1'b0;
    bus.fetch_data_valid = 1'b0;
    bus.fetch_data       = '0;
    resp_pending         = 1'b0;
    resp_delay           = 0;
    resp_addr            = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.fetch_req_ready  = 1'b0;
      bus.fetch_data_valid = 1'b0;
      if (resp_pending) begin
        if (resp_delay == 0) begin
          bus.fetch_data_valid = 1'b1;
          bus.fetch_data       = mem_read(resp_addr);
          resp_pending         = 1'b0;
        end else begin
          resp_delay--;
        end
      end else if (bus.fetch_req_valid === 1'b1 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
        bus.fetch_req_ready = 1'b1;
        resp_addr           = bus.fetch_addr;
        req_log.push_back(bus.fetch_addr);
        resp_pending        = 1'b1;
        resp_delay          = rnd_mode ? int'($urandom_range(0, 2)) : fixed_delay;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic read_pc(output logic [15:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      comp_counter = 3'(i);
      #1;
      v = v | (16'(pc_data_out) << (2 * i));
    end
  endtask

  task automatic drain_log();
    logic [15:0] a;
    while (req_log.size() > 0) begin
      a = req_log.pop_front();
      chk("fetch_addr", 32'(a), 32'(exp_fetch));
      exp_fetch = exp_fetch + 16'd2;
    end
  endtask

  // Decoder model: each retired instruction (and its imm16) consumes the next word of the stream
  task automatic consume(input bit use_imm, input int ndig);
    int          t;
    logic [15:0] exp_inst, exp_imm, p;
    logic [1:0]  dexp;
    t = 0;
    while (!inst_valid && t < 200) begin @(negedge clk); t++; end
    chk("inst_valid_wait", 32'(inst_valid), 1);
    exp_inst  = mem_read(cons_addr);
    chk("inst", 32'(inst), 32'(exp_inst));
    cons_addr = cons_addr + 16'd2;
    if (use_imm) begin
      load_imm16 = 1'b1;
      t = 0;
      while (!imm16_loaded && t < 200) begin @(negedge clk); t++; end
      load_imm16 = 1'b0;
      chk("imm16_loaded_wait", 32'(imm16_loaded), 1);
      exp_imm   = mem_read(cons_addr);
      cons_addr = cons_addr + 16'd2;
    end else begin
      exp_imm = {{8{exp_inst[7]}}, exp_inst[7:0]};
    end
    chk("imm_full", 32'(imm_full), 32'(exp_imm));
    for (int k = 0; k < ndig; k++) begin
      dexp = 2'((exp_imm >> (2 * (k % 8))) & 16'h3);
      chk("imm_digit", 32'(imm_data_out), 32'(dexp));
      next_imm_data = 1'b1;
      @(negedge clk);
      next_imm_data = 1'b0;
    end
    read_pc(p);
    chk("pc", 32'(p), 32'(cons_addr));
    drain_log();
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
  endtask

  task automatic flush_to(input logic [15:0] v);
    int          t;
    logic [15:0] p;
    block_prefetch = 1'b1;
    t = 0;
    while (!prefetch_idle && t < 100) begin @(negedge clk); t++; end
    chk("flush_idle_wait", 32'(prefetch_idle), 1);
    repeat (4) @(negedge clk);
    drain_log();
    for (int i = 0; i < 8; i++) begin
      comp_counter = 3'(i);
      pc_data_in   = 2'(v >> (2 * i));
      write_pc     = 1'b1;
      @(negedge clk);
    end
    write_pc    = 1'b0;
    ext_pc_next = 1'b1;
    @(negedge clk);
    ext_pc_next = 1'b0;
    chk("flush_inst_valid", 32'(inst_valid), 0);
    chk("flush_imm16_loaded", 32'(imm16_loaded), 0);
    read_pc(p);
    chk("flush_pc", 32'(p), 32'(v));
    exp_fetch      = v;
    cons_addr      = v;
    block_prefetch = 1'b0;
  endtask

  initial begin
    int          t;
    logic [15:0] p;
    n_tests = 0;
    n_fail  = 0;
    salt    = 16'($urandom);
    mem[16'h0000] = 16'h8001;
    mem[16'h0002] = 16'h8002;
    mem[16'h0100] = 16'h1041;
    mem[16'h0102] = 16'h1234;
    rnd_mode       = 1'b0;
    fixed_delay    = 4;
    reset          = 1'b1;
    inst_done      = 1'b0;
    load_imm16     = 1'b0;
    next_imm_data  = 1'b0;
    block_prefetch = 1'b1;
    write_pc       = 1'b0;
    ext_pc_next    = 1'b0;
    comp_counter   = '0;
    pc_data_in     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_imm16_loaded", 32'(imm16_loaded), 0);
    chk("rst_fetch_req_valid", 32'(bus.fetch_req_valid), 0);
    chk("rst_prefetch_idle", 32'(prefetch_idle), 1);
    read_pc(p);
    chk("rst_pc", 32'(p), 0);

    // Reset while a response is outstanding; the late response must be dropped
    block_prefetch = 1'b0;
    t = 0;
    while (!(!prefetch_idle && !bus.fetch_req_valid) && t < 50) begin @(negedge clk); t++; end
    chk("wait_state_reached", 32'(t < 50), 1);
    block_prefetch = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_log.delete();
    repeat (10) @(negedge clk);
    chk("stray_inst_valid", 32'(inst_valid), 0);
    chk("stray_prefetch_idle", 32'(prefetch_idle), 1);
    read_pc(p);
    chk("stray_pc", 32'(p), 0);

    // Directed stream 0x8001, 0x8002 with one-cycle memory latency
    fixed_delay    = 0;
    cons_addr      = 16'h0000;
    exp_fetch      = 16'h0000;
    block_prefetch = 1'b0;
    t = 0;
    while (!bus.fetch_data_valid && t < 50) begin @(negedge clk); t++; end
    chk("first_data_seen", 32'(bus.fetch_data_valid), 1);
    @(negedge clk);
    chk("no_bypass_inst_valid", 32'(inst_valid), 0);
    @(negedge clk);
    chk("first_inst_valid", 32'(inst_valid), 1);
    chk("first_inst", 32'(inst), 32'(mem_read(16'h0000)));
    cons_addr = 16'h0002;
    read_pc(p);
    chk("pc_after_first", 32'(p), 2);

    // Inst slot held: two queued words then fetching must stop
    repeat (40) @(negedge clk);
    chk("full_fetch_req_valid", 32'(bus.fetch_req_valid), 0);
    chk("full_prefetch_idle", 32'(prefetch_idle), 1);
    chk("full_fetch_count", 32'(req_log.size()), 3);
    drain_log();
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;
    t = 0;
    while (!bus.fetch_req_valid && t < 20) begin @(negedge clk); t++; end
    chk("refetch_after_done", 32'(bus.fetch_req_valid), 1);
    consume(1'b0, 3);
    consume(1'b0, 0);

    // PC redirect, then an imm16 instruction and digit walks including wrap
    flush_to(16'h0100);
    consume(1'b1, 8);
    consume(1'b0, 10);

    // Address wrap and randomized decoder/memory timing
    flush_to(16'hFFFE);
    rnd_mode = 1'b1;
    repeat (30) consume(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
    flush_to(16'($urandom) & 16'hFFFE);
    repeat (10) consume(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    drain_log();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
